alu_op_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_op_sequencer_if.sv | 36 +++
 rtl/op_decode.sv | 36 +++
 rtl/alu_op_sequencer.sv | 99 +++++++++
 tb/tb_alu_op_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU command path: opcodes, one-hot result-mux selects
// and the sequencer FSM state type.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 12;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_AND     = 4'd0;
  localparam logic [OP_W-1:0] OP_OR      = 4'd1;
  localparam logic [OP_W-1:0] OP_NOT     = 4'd2;
  localparam logic [OP_W-1:0] OP_XOR     = 4'd3;
  localparam logic [OP_W-1:0] OP_NAND    = 4'd4;
  localparam logic [OP_W-1:0] OP_NOR     = 4'd5;
  localparam logic [OP_W-1:0] OP_XNOR    = 4'd6;
  localparam logic [OP_W-1:0] OP_ADD     = 4'd7;
  localparam logic [OP_W-1:0] OP_SUB     = 4'd8;
  localparam logic [OP_W-1:0] OP_SHRIGHT = 4'd9;
  localparam logic [OP_W-1:0] OP_SHLEFT  = 4'd10;
  localparam logic [OP_W-1:0] OP_CLEAR   = 4'd11;

  // Result-mux select lines; bit position equals the opcode value.
  localparam logic [SEL_W-1:0] SEL_AND     = 12'h001;
  localparam logic [SEL_W-1:0] SEL_OR      = 12'h002;
  localparam logic [SEL_W-1:0] SEL_NOT     = 12'h004;
  localparam logic [SEL_W-1:0] SEL_XOR     = 12'h008;
  localparam logic [SEL_W-1:0] SEL_NAND    = 12'h010;
  localparam logic [SEL_W-1:0] SEL_NOR     = 12'h020;
  localparam logic [SEL_W-1:0] SEL_XNOR    = 12'h040;
  localparam logic [SEL_W-1:0] SEL_ADD     = 12'h080;
  localparam logic [SEL_W-1:0] SEL_SUB     = 12'h100;
  localparam logic [SEL_W-1:0] SEL_SHRIGHT = 12'h200;
  localparam logic [SEL_W-1:0] SEL_SHLEFT  = 12'h400;
  localparam logic [SEL_W-1:0] SEL_CLEAR   = 12'h800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, datapath and response signals between the instruction source,
// the sequencer and the ALU result mux.
interface alu_op_sequencer_if;
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              cmd_use_acc;

  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              sub_mode;
  logic [DATA_W-1:0] mux_res;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [DATA_W-1:0] acc;

  // master: instruction source plus datapath model; slave: the sequencer.
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready, mux_res,
    input  cmd_ready, sel, op_a, op_b, sub_mode, rsp_valid, rsp_data, rsp_err, acc
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready, mux_res,
    output cmd_ready, sel, op_a, op_b, sub_mode, rsp_valid, rsp_data, rsp_err, acc
  );

endinterface

// File: rtl/op_decode.sv
// Combinational opcode expansion into the one-hot result-mux select,
// the add/sub control and an illegal-opcode flag.
module op_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [SEL_W-1:0] sel,
  output logic             sub_mode,
  output logic             illegal
);

  always_comb begin
    sel      = '0;
    sub_mode = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_AND:     sel = SEL_AND;
      OP_OR:      sel = SEL_OR;
      OP_NOT:     sel = SEL_NOT;
      OP_XOR:     sel = SEL_XOR;
      OP_NAND:    sel = SEL_NAND;
      OP_NOR:     sel = SEL_NOR;
      OP_XNOR:    sel = SEL_XNOR;
      OP_ADD:     sel = SEL_ADD;
      OP_SUB: begin
        sel      = SEL_SUB;
        sub_mode = 1'b1;
      end
      OP_SHRIGHT: sel = SEL_SHRIGHT;
      OP_SHLEFT:  sel = SEL_SHLEFT;
      OP_CLEAR:   sel = SEL_CLEAR;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts an opcode and operands, drives the result-mux select for EXEC_CYCLES
// cycles, captures the mux output into the accumulator and returns it.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  alu_op_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EXEC_CYCLES - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OP_W-1:0]   op_code_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic [OP_W-1:0]   dec_op;
  logic [SEL_W-1:0]  dec_sel;
  logic              dec_sub;
  logic              dec_ill;
  logic              accept;
  logic [DATA_W-1:0] cap_val;

  // One decoder serves both phases: it checks the incoming opcode while idle
  // and expands the latched opcode while executing.
  assign dec_op = (state_q == ST_IDLE) ? bus.cmd_op : op_code_q;

  op_decode u_op_decode (
    .op       (dec_op),
    .sel      (dec_sel),
    .sub_mode (dec_sub),
    .illegal  (dec_ill)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign cap_val       = (op_code_q == OP_CLEAR) ? '0 : bus.mux_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_code_q  <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      acc_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_code_q <= bus.cmd_op;
            op_a_q    <= bus.cmd_use_acc ? acc_q : bus.cmd_a;
            op_b_q    <= bus.cmd_b;
            cnt_q     <= '0;
            if (dec_ill) begin
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
              state_q    <= ST_RESP;
            end else begin
              state_q <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            rsp_data_q <= cap_val;
            acc_q      <= cap_val;
            rsp_err_q  <= 1'b0;
            state_q    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.sel       = (state_q == ST_EXEC) ? dec_sel : '0;
  assign bus.sub_mode  = (state_q == ST_EXEC) && dec_sub;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.acc       = acc_q;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed table, backpressure and reset-abort
// sequences, and random commands against a behavioural accumulator model.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic rst4;
  always #5 clk = ~clk;

  alu_op_sequencer_if if1 ();
  alu_op_sequencer_if if4 ();

  alu_op_sequencer #(.EXEC_CYCLES(1)) dut1 (.clk(clk), .rst(rst),  .bus(if1));
  alu_op_sequencer #(.EXEC_CYCLES(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4));

  // Datapath stand-in: the mux output the selected ALU function would produce.
  function automatic logic [15:0] mux_model(input logic [11:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      12'h001: return a & b;
      12'h002: return a | b;
      12'h004: return ~a;
      12'h008: return a ^ b;
      12'h010: return ~(a & b);
      12'h020: return ~(a | b);
      12'h040: return ~(a ^ b);
      12'h080: return a + b;
      12'h100: return a - b;
      12'h200: return a >> 1;
      12'h400: return a << 1;
      default: return 16'h0000;
    endcase
  endfunction

  // Expected result of a whole command, from the opcode alone.
  function automatic logic [15:0] ref_res(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return ~a;
      4'd3:  return a ^ b;
      4'd4:  return ~(a & b);
      4'd5:  return ~(a | b);
      4'd6:  return ~(a ^ b);
      4'd7:  return a + b;
      4'd8:  return a - b;
      4'd9:  return a >> 1;
      4'd10: return a << 1;
      default: return 16'h0000;
    endcase
  endfunction

  logic        force_en = 1'b0;
  logic [15:0] force_val = 16'hBEEF;
  assign if1.mux_res = force_en ? force_val : mux_model(if1.sel, if1.op_a, if1.op_b);
  assign if4.mux_res = mux_model(if4.sel, if4.op_a, if4.op_b);

  logic cur = 1'b0;
  logic        m_cmd_ready, m_sub, m_rsp_valid, m_rsp_err;
  logic [11:0] m_sel;
  logic [15:0] m_op_a, m_op_b, m_rsp_data, m_acc;
  assign m_cmd_ready = cur ? if4.cmd_ready : if1.cmd_ready;
  assign m_sub       = cur ? if4.sub_mode  : if1.sub_mode;
  assign m_rsp_valid = cur ? if4.rsp_valid : if1.rsp_valid;
  assign m_rsp_err   = cur ? if4.rsp_err   : if1.rsp_err;
  assign m_sel       = cur ? if4.sel       : if1.sel;
  assign m_op_a      = cur ? if4.op_a      : if1.op_a;
  assign m_op_b      = cur ? if4.op_b      : if1.op_b;
  assign m_rsp_data  = cur ? if4.rsp_data  : if1.rsp_data;
  assign m_acc       = cur ? if4.acc       : if1.acc;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic ua);
    if (cur) begin
      if4.cmd_valid = v; if4.cmd_op = op; if4.cmd_a = a; if4.cmd_b = b; if4.cmd_use_acc = ua;
    end else begin
      if1.cmd_valid = v; if1.cmd_op = op; if1.cmd_a = a; if1.cmd_b = b; if1.cmd_use_acc = ua;
    end
  endtask

  task automatic set_rr(input logic v);
    if (cur) if4.rsp_ready = v;
    else     if1.rsp_ready = v;
  endtask

  // Entered at the negedge following the accept edge.
  task automatic complete(input string tag, input int e_cyc, input int hold,
                          input logic [11:0] e_sel, input logic e_sub,
                          input logic [15:0] e_opa, input logic [15:0] e_opb,
                          input logic [15:0] e_res, input logic e_err, input logic [15:0] e_acc);
    int lat = 0;
    int sel_hits = 0;
    int sel_bad = 0;
    int bp_bad = 0;
    logic [15:0] held;
    for (int j = 1; j <= 40 && lat == 0; j++) begin
      if (j > 1) @(negedge clk);
      if (j == 1) begin
        chk({tag, "/op_a"}, m_op_a, e_opa);
        chk({tag, "/op_b"}, m_op_b, e_opb);
      end
      if (m_cmd_ready) sel_bad++;
      if (m_rsp_valid) begin
        lat = j;
        if (m_sel != 12'h000 || m_sub) sel_bad++;
      end else if (e_sel != 12'h000 && m_sel == e_sel) begin
        sel_hits++;
        if (m_sub !== e_sub) sel_bad++;
      end else if (m_sel != 12'h000 || m_sub) begin
        sel_bad++;
      end
    end
    chk({tag, "/latency"}, lat, e_err ? 1 : e_cyc + 1);
    chk({tag, "/sel_cycles"}, sel_hits, e_err ? 0 : e_cyc);
    chk({tag, "/sel_bad"}, sel_bad, 0);
    chk({tag, "/rsp_data"}, m_rsp_data, e_res);
    chk({tag, "/rsp_err"}, m_rsp_err, e_err);
    chk({tag, "/acc"}, m_acc, e_acc);
    held = m_rsp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!m_rsp_valid || m_rsp_data !== held || m_cmd_ready) bp_bad++;
    end
    if (hold > 0) chk({tag, "/backpressure_hold"}, bp_bad, 0);
    set_rr(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_rr(1'b0);
    chk({tag, "/rsp_valid_drop"}, m_rsp_valid, 1'b0);
  endtask

  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic ua, input int hold, input int e_cyc,
                         input logic [11:0] e_sel, input logic e_sub, input logic [15:0] e_opa,
                         input logic [15:0] e_res, input logic e_err, input logic [15:0] e_acc);
    chk({tag, "/cmd_ready"}, m_cmd_ready, 1'b1);
    drive_cmd(1'b1, op, a, b, ua);
    @(posedge clk);
    @(negedge clk);
    drive_cmd(1'b0, op, a, b, ua);
    complete(tag, e_cyc, hold, e_sel, e_sub, e_opa, b, e_res, e_err, e_acc);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        ua, frc;
    logic [11:0] e_sel;
    logic        e_sub;
    logic [15:0] e_opa, e_res;
    logic        e_err;
    logic [15:0] e_acc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b, opa, res, acc_m;
    logic        ua, legal;
    int          hold, bad;

    tbl[0] = '{4'd7,  16'h0003, 16'h0004, 1'b0, 1'b0, 12'h080, 1'b0, 16'h0003, 16'h0007, 1'b0, 16'h0007};
    tbl[1] = '{4'd8,  16'hAAAA, 16'h0002, 1'b1, 1'b0, 12'h100, 1'b1, 16'h0007, 16'h0005, 1'b0, 16'h0005};
    tbl[2] = '{4'd13, 16'h1234, 16'h5678, 1'b0, 1'b0, 12'h000, 1'b0, 16'h1234, 16'h0000, 1'b1, 16'h0005};
    tbl[3] = '{4'd11, 16'h1111, 16'h2222, 1'b0, 1'b1, 12'h800, 1'b0, 16'h1111, 16'h0000, 1'b0, 16'h0000};
    tbl[4] = '{4'd2,  16'h00FF, 16'h0000, 1'b0, 1'b0, 12'h004, 1'b0, 16'h00FF, 16'hFF00, 1'b0, 16'hFF00};
    tbl[5] = '{4'd10, 16'h5555, 16'h0003, 1'b1, 1'b0, 12'h400, 1'b0, 16'hFF00, 16'hFE00, 1'b0, 16'hFE00};
    tbl[6] = '{4'd4,  16'hFFFF, 16'h0F0F, 1'b0, 1'b0, 12'h010, 1'b0, 16'hFFFF, 16'hF0F0, 1'b0, 16'hF0F0};

    rst = 1'b1;
    rst4 = 1'b1;
    if1.rsp_ready = 1'b0;
    if4.rsp_ready = 1'b0;
    cur = 1'b1; drive_cmd(1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
    cur = 1'b0; drive_cmd(1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);

    chk("reset/cmd_ready", m_cmd_ready, 1'b0);
    chk("reset/sel", m_sel, 12'h000);
    chk("reset/sub_mode", m_sub, 1'b0);
    chk("reset/op_a", m_op_a, 16'h0000);
    chk("reset/op_b", m_op_b, 16'h0000);
    chk("reset/acc", m_acc, 16'h0000);
    chk("reset/rsp_data", m_rsp_data, 16'h0000);
    chk("reset/rsp_valid", m_rsp_valid, 1'b0);
    chk("reset/rsp_err", m_rsp_err, 1'b0);
    rst = 1'b0;
    rst4 = 1'b0;
    @(negedge clk);
    chk("reset/cmd_ready_after", m_cmd_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      force_en = tbl[i].frc;
      run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ua, 0, 1,
              tbl[i].e_sel, tbl[i].e_sub, tbl[i].e_opa, tbl[i].e_res, tbl[i].e_err, tbl[i].e_acc);
      force_en = 1'b0;
    end

    // Response held off for 5 cycles while the next command waits on the bus.
    chk("bp/cmd_ready", m_cmd_ready, 1'b1);
    drive_cmd(1'b1, 4'd3, 16'hF0F0, 16'h0FF0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_cmd(1'b1, 4'd1, 16'h0001, 16'h0100, 1'b0);
    complete("bp_xor", 1, 5, 12'h008, 1'b0, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 16'hFF00);
    chk("bp/cmd_ready_next", m_cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive_cmd(1'b0, 4'd1, 16'h0001, 16'h0100, 1'b0);
    complete("bp_or", 1, 0, 12'h002, 1'b0, 16'h0001, 16'h0100, 16'h0101, 1'b0, 16'h0101);

    acc_m = 16'h0101;
    for (int i = 0; i < 60; i++) begin
      op    = 4'($urandom_range(0, 15));
      a     = 16'($urandom);
      b     = 16'($urandom);
      ua    = 1'($urandom_range(0, 1));
      hold  = $urandom_range(0, 2);
      legal = (op < 4'd12);
      opa   = ua ? acc_m : a;
      res   = legal ? ref_res(op, opa, b) : 16'h0000;
      run_cmd($sformatf("rnd%0d_op%0d", i, op), op, a, b, ua, hold, 1,
              legal ? 12'(1 << op) : 12'h000, (op == 4'd8), opa, res, !legal,
              legal ? res : acc_m);
      if (legal) acc_m = res;
    end

    // Four-cycle execute window, then a reset that aborts an in-flight command.
    cur = 1'b1;
    run_cmd("e4_add", 4'd7, 16'h0010, 16'h0020, 1'b0, 1, 4,
            12'h080, 1'b0, 16'h0010, 16'h0030, 1'b0, 16'h0030);
    chk("e4/cmd_ready", m_cmd_ready, 1'b1);
    drive_cmd(1'b1, 4'd8, 16'h0005, 16'h0001, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_cmd(1'b0, 4'd8, 16'h0005, 16'h0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("e4_abort/sel_exec3", m_sel, 12'h100);
    chk("e4_abort/sub_exec3", m_sub, 1'b1);
    rst4 = 1'b1;
    @(negedge clk);
    chk("e4_abort/sel", m_sel, 12'h000);
    chk("e4_abort/acc", m_acc, 16'h0000);
    chk("e4_abort/rsp_valid", m_rsp_valid, 1'b0);
    chk("e4_abort/cmd_ready_in_rst", m_cmd_ready, 1'b0);
    rst4 = 1'b0;
    @(negedge clk);
    chk("e4_abort/cmd_ready_after", m_cmd_ready, 1'b1);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (m_rsp_valid || m_sel != 12'h000) bad++;
    end
    chk("e4_abort/no_response", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
